// File: rtl/team_06_period_meter.sv
// team_06_period_meter: measures the period of a slow asynchronous signal
// in clk cycles. sig_in is synchronised, rising edges are detected and the
// clk cycles between consecutive edges are reported on period with a
// valid/ack handshake, a sticky overrun flag and a sticky timeout flag.
//
// Optional feature: define TEAM_06_PERIOD_METER_AVG_EN to report the mean of
// the previous and current raw periods instead of the raw period.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for the first rising edge
// MEASURE | counting clk cycles since the last rising edge

module team_06_period_meter #(
   parameter int CNT_W   = 25,
   parameter int TIMEOUT = 25_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             clear,
   input  logic             ack,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             overrun,
   output logic             timeout
);

   typedef enum logic {IDLE, MEASURE} state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] raw;
   logic [CNT_W-1:0] period_nxt;
   logic             sync1, sync2, sync3;
   logic             edge_det;
   logic             latch;
   logic             tmo_hit;

   assign edge_det = sync2 & ~sync3;
   assign raw      = count + CNT_W'(1);

   // Synchroniser and edge flop; soft clear leaves them running.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= sig_in;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else if (clear)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state, period latch strobe and timeout strobe.
   always_comb begin
      state_nxt = state;
      latch     = 1'b0;
      tmo_hit   = 1'b0;
      case (state)
         IDLE: begin
            if (edge_det)
               state_nxt = MEASURE;
         end
         MEASURE: begin
            if (edge_det) begin
               latch = 1'b1;
            end else if (count == TIMEOUT_M1) begin
               tmo_hit   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef TEAM_06_PERIOD_METER_AVG_EN
   logic [CNT_W-1:0] prev_raw;
   logic             have_prev;
   logic [CNT_W:0]   sum;

   assign sum        = {1'b0, prev_raw} + {1'b0, raw};
   assign period_nxt = have_prev ? sum[CNT_W:1] : raw;

   // Averaging history; forgotten whenever the measurement chain restarts.
   always_ff @(posedge clk) begin
      if (!rst || clear || tmo_hit) begin
         prev_raw  <= '0;
         have_prev <= 1'b0;
      end else if (latch) begin
         prev_raw  <= raw;
         have_prev <= 1'b1;
      end
   end
`else
   assign period_nxt = raw;
`endif

   // Period counter; the timeout compare keeps it from ever wrapping.
   always_ff @(posedge clk) begin
      if (!rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (state == MEASURE && !latch && !tmo_hit)
         count <= count + CNT_W'(1);
      else
         count <= '0;
   end

   // Result register and handshake / sticky status flags.
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         period       <= '0;
         period_valid <= 1'b0;
         overrun      <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         if (latch) begin
            period       <= period_nxt;
            period_valid <= 1'b1;
            timeout      <= 1'b0;
            if (period_valid && !ack)
               overrun <= 1'b1;
         end else begin
            if (period_valid && ack)
               period_valid <= 1'b0;
            if (tmo_hit)
               timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_team_06_period_meter.sv
// Directed bench for team_06_period_meter with TIMEOUT = 100, CNT_W = 25.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_team_06_period_meter;

   localparam int CNT_W   = 25;
   localparam int TIMEOUT = 100;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             sig_in = 1'b0;
   logic             clear = 1'b0;
   logic             ack = 1'b0;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             overrun;
   logic             timeout;

   int checks = 0;
   int failures = 0;

   team_06_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .sig_in       (sig_in),
      .clear        (clear),
      .ack          (ack),
      .period       (period),
      .period_valid (period_valid),
      .overrun      (overrun),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      bit    ack;
      int    gap;
      int    exp_period;
      bit    exp_valid;
      bit    exp_overrun;
      bit    exp_timeout;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input int p, input bit v, input bit o, input bit t);
      chk({name, ".period"}, 32'(period), p);
      chk({name, ".valid"}, 32'(period_valid), 32'(v));
      chk({name, ".overrun"}, 32'(overrun), 32'(o));
      chk({name, ".timeout"}, 32'(timeout), 32'(t));
   endtask

   // Raise sig_in and step past the posedge that detects the edge.
   task automatic rise3();
      sig_in = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   // Drop sig_in and wait so the next rise lands gap cycles after the last.
   task automatic rest(input int gap);
      sig_in = 1'b0;
      repeat (gap - 3) @(negedge clk);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{"first_edge",   1'b1, 20,  0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{"p20_a",        1'b1, 20, 20, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{"p20_b",        1'b1, 20, 20, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{"p20_noack",    1'b0, 30, 20, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{"p30_overrun",  1'b0, 20, 30, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{"p20_ack",      1'b1, 20, 20, 1'b1, 1'b1, 1'b0};

      // Reset state
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_all("reset", 0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);

`ifndef TEAM_06_PERIOD_METER_AVG_EN
      // Edge sequence table
      for (int i = 0; i < 6; i++) begin
         ack = vecs[i].ack;
         rise3();
         chk_all(vecs[i].name, vecs[i].exp_period, vecs[i].exp_valid,
                 vecs[i].exp_overrun, vecs[i].exp_timeout);
         if (vecs[i].ack && vecs[i].exp_valid) begin
            @(negedge clk);
            chk({vecs[i].name, ".pulse1"}, 32'(period_valid), 0);
            rest(vecs[i].gap - 1);
         end else begin
            rest(vecs[i].gap);
         end
      end
      chk("ack_keeps_overrun", 32'(overrun), 1);
`endif

      // Clear wipes everything set so far
      ack = 1'b0;
      sig_in = 1'b0;
      do_clear();
      chk_all("clear", 0, 1'b0, 1'b0, 1'b0);

`ifndef TEAM_06_PERIOD_METER_AVG_EN
      // Latch and ack in the same cycle
      do_clear();
      rise3();
      rest(20);
      rise3();
      chk("same_pre.period", 32'(period), 20);
      rest(25);
      sig_in = 1'b1;
      repeat (2) @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      chk_all("same_cycle", 25, 1'b1, 1'b0, 1'b0);
      sig_in = 1'b0;
      @(negedge clk);
      chk("same_cycle.ackd", 32'(period_valid), 0);
      ack = 1'b0;
`endif

      // Timeout exactly TIMEOUT cycles after the detected edge
      do_clear();
      rise3();
      sig_in = 1'b0;
      repeat (TIMEOUT - 1) @(negedge clk);
      chk("tmo_early", 32'(timeout), 0);
      @(negedge clk);
      chk_all("tmo", 0, 1'b0, 1'b0, 1'b1);
      rise3();
      chk_all("tmo_idle_edge", 0, 1'b0, 1'b0, 1'b1);
      rest(20);
      rise3();
      chk_all("tmo_recover", 20, 1'b1, 1'b0, 1'b0);
      sig_in = 1'b0;

      // Reset mid-measurement discards the partial count
      do_clear();
      rise3();
      rest(20);
      rise3();
      chk("pre_rst.valid", 32'(period_valid), 1);
      sig_in = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk_all("mid_rst", 0, 1'b0, 1'b0, 1'b0);
      rise3();
      chk_all("post_rst_edge", 0, 1'b0, 1'b0, 1'b0);
      sig_in = 1'b0;

`ifdef TEAM_06_PERIOD_METER_AVG_EN
      // Averaging: first raw, then mean; clear resets history
      ack = 1'b1;
      do_clear();
      rise3();
      rest(20);
      rise3();
      chk("avg_first", 32'(period), 20);
      rest(30);
      rise3();
      chk("avg_mean", 32'(period), 25);
      sig_in = 1'b0;
      do_clear();
      rise3();
      rest(40);
      rise3();
      chk("avg_after_clear", 32'(period), 40);
      sig_in = 1'b0;
      ack = 1'b0;
`endif

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/team_06_period_meter.md
TEAM_06_PERIOD_METER -- requirements
Module: team_06_period_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 25, meaning the width of the period counter and of the period output.
REQ-002 The block SHALL have parameter TIMEOUT, default 25_000_000, meaning the clk cycles without a rising edge before the measurement is abandoned (2 <= TIMEOUT <= 2^CNT_W - 1).
REQ-003 clk  input  1  system clock; one clock domain, all flops on posedge clk.
REQ-004 rst  input  1  synchronous active-low reset; active when rst = 0, sampled on posedge clk.
REQ-005 sig_in  input  1  slow periodic signal to measure (e.g. a divided clock); asynchronous to clk.
REQ-006 clear  input  1  synchronous soft clear, active high.
REQ-007 ack  input  1  consumer acknowledge of the current period.
REQ-008 period  output  CNT_W  last measured period, in clk cycles.
REQ-009 period_valid  output  1  a new period is available and not yet acknowledged.
REQ-010 overrun  output  1  sticky; a period was overwritten before it was acknowledged.
REQ-011 timeout  output  1  sticky; no rising edge arrived within TIMEOUT cycles.

Function
REQ-012 sig_in SHALL pass through a 2-flop synchronizer, then a third flop for edge detection; a rising edge is detected when sync2 = 1 and sync3 = 0.
REQ-013 The FSM SHALL have states IDLE (wait for first edge), MEASURE (counting), and no others.
REQ-014 IDLE: on a detected edge, go to MEASURE with count = 0; no period is produced.
REQ-015 MEASURE: count increments by 1 each cycle with no edge; on a detected edge, latch period = count + 1, reload count = 0, and stay in MEASURE.
REQ-016 Consecutive detected edges N cycles apart SHALL yield period = N exactly; synchronizer latency cancels.
REQ-017 Timeout: in MEASURE, when count = TIMEOUT - 1 and no edge is detected, go to IDLE and set timeout = 1; period is unchanged and period_valid is not set.
REQ-018 When period is latched, period_valid SHALL be 1 in the next cycle and held until ack = 1 is sampled with period_valid = 1.
REQ-019 A latch with period_valid = 1 and ack = 0 in the same cycle SHALL set overrun = 1 and overwrite period; period_valid stays 1.
REQ-020 A latch and ack in the same cycle SHALL leave period_valid = 1 with the new value and SHALL NOT set overrun.
REQ-021 timeout SHALL clear on the next latched period; overrun SHALL clear only on clear or reset.
REQ-022 clear = 1 SHALL force IDLE, count = 0, period = 0, period_valid = 0, overrun = 0, and timeout = 0 in the next cycle; the synchronizer flops are kept.
REQ-023 count SHALL never wrap; the timeout at TIMEOUT - 1 bounds it below 2^CNT_W.
REQ-024 Minimum measurable period is 2 cycles; sig_in pulses narrower than 1 clk cycle MAY be missed.

Reset
REQ-025 With rst = 0 at posedge clk: the synchronizer and edge flops = 0, state = IDLE, count = 0, period = 0, period_valid = 0, overrun = 0, timeout = 0.
REQ-026 Priority is rst, then clear, then normal operation; reset mid-measurement discards the partial count.

Configuration
REQ-027 Macro TEAM_06_PERIOD_METER_AVG_EN: when defined, period SHALL be (previous raw period + current raw period) >> 1, with a CNT_W+1-bit sum and truncation.
REQ-028 With the macro defined, the first period after IDLE SHALL be the raw value, and the averaging history SHALL be cleared by rst, clear and timeout.
REQ-029 When the macro is not defined, period is the raw measurement and no averaging register exists.

Verification (TIMEOUT = 100, CNT_W = 25)
REQ-030 Square wave on sig_in, period 20 clk cycles, ack tied 1 -> from the second edge onward, period = 20 each edge and period_valid high for exactly 1 cycle.
REQ-031 Edges at spacing 20 then 30, ack = 0 -> period = 30, period_valid = 1, overrun = 1; then ack = 1 -> period_valid = 0, overrun stays 1.
REQ-032 One edge then sig_in held at 0 -> timeout = 1 exactly 100 cycles after the edge is detected, FSM in IDLE, period unchanged.
REQ-033 rst = 0 for 1 cycle mid-measurement at count = 10 -> all outputs 0; the next single edge produces no period.
REQ-034 With TEAM_06_PERIOD_METER_AVG_EN defined, spacings 20 then 30 -> period = 20, then 25; clear, then spacing 40 -> period = 40.
